// File: rtl/pipe_mw_elastic_reg_if.sv
// MEM->WB bundle handshake interface: MEM-side offer, WB-side head and occupancy.
// slave = the elastic register, master = the MEM/WB stages driving it.
interface pipe_mw_elastic_reg_if #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int CNT_W  = 4
);
  logic              mvalid;
  logic              mready;
  logic              mwreg;
  logic              mm2reg;
  logic [RN_W-1:0]   mrn;
  logic [DATA_W-1:0] malu;
  logic [DATA_W-1:0] mmo;
  logic              wvalid;
  logic              wready;
  logic              wwreg;
  logic              wm2reg;
  logic [RN_W-1:0]   wrn;
  logic [DATA_W-1:0] walu;
  logic [DATA_W-1:0] wmo;
  logic [DATA_W-1:0] wdata;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  mvalid, mwreg, mm2reg, mrn, malu, mmo, wready,
    output mready, wvalid, wwreg, wm2reg, wrn, walu, wmo, wdata, count
  );

  modport master (
    output mvalid, mwreg, mm2reg, mrn, malu, mmo, wready,
    input  mready, wvalid, wwreg, wm2reg, wrn, walu, wmo, wdata, count
  );
endinterface

// File: rtl/pipe_mw_elastic_reg.sv
// DEPTH-entry elastic MEM/WB pipeline register with flush and occupancy count.
// Optional MW_BYPASS_EN: zero-latency m-to-w pass-through while the buffer is empty.
module pipe_mw_elastic_reg #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic flush,
  pipe_mw_elastic_reg_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic [RN_W-1:0]   rn;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mo;
  } ent_t;

  ent_t             slots [DEPTH];
  ent_t             in_ent;
  ent_t             out_ent;
  ptr_t             rp_reg, rp_next;
  ptr_t             wp_reg, wp_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             empty;
  logic             bypass_on;
  logic             bypass_take;
  logic             push;
  logic             pop;
  logic             out_valid;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign in_ent = '{wreg: bus.mwreg, m2reg: bus.mm2reg, rn: bus.mrn,
                    alu: bus.malu, mo: bus.mmo};

  assign empty      = (count_reg == '0);
  assign bus.mready = (count_reg < CNT_W'(DEPTH));

`ifdef MW_BYPASS_EN
  assign bypass_on = empty && !flush;
`else
  assign bypass_on = 1'b0;
`endif

  // A bypassed bundle consumed by WB this cycle must not also be stored.
  assign bypass_take = bypass_on && bus.mvalid && bus.wready;
  assign push        = bus.mvalid && bus.mready && !bypass_take;
  assign pop         = !empty && bus.wready;

  always_comb begin
    rp_next    = rp_reg;
    wp_next    = wp_reg;
    count_next = count_reg;
    if (flush) begin
      rp_next    = '0;
      wp_next    = '0;
      count_next = '0;
    end else begin
      if (push) wp_next = ptr_inc(wp_reg);
      if (pop)  rp_next = ptr_inc(rp_reg);
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rp_reg    <= '0;
      wp_reg    <= '0;
      count_reg <= '0;
    end else begin
      rp_reg    <= rp_next;
      wp_reg    <= wp_next;
      count_reg <= count_next;
    end
  end

  // One register per slot; contents need no reset since count gates visibility.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      ent_t slot_reg;
      always_ff @(posedge clock) begin
        if (!reset && !flush && push && (wp_reg == ptr_t'(gi))) begin
          slot_reg <= in_ent;
        end
      end
      assign slots[gi] = slot_reg;
    end
  endgenerate

  always_comb begin
    out_ent   = '0;
    out_valid = 1'b0;
    if (!empty) begin
      out_ent   = slots[rp_reg];
      out_valid = 1'b1;
    end else if (bypass_on && bus.mvalid) begin
      out_ent   = in_ent;
      out_valid = 1'b1;
    end
  end

  assign bus.wvalid = out_valid;
  assign bus.wwreg  = out_ent.wreg;
  assign bus.wm2reg = out_ent.m2reg;
  assign bus.wrn    = out_ent.rn;
  assign bus.walu   = out_ent.alu;
  assign bus.wmo    = out_ent.mo;
  assign bus.wdata  = out_ent.m2reg ? out_ent.mo : out_ent.alu;
  assign bus.count  = count_reg;
endmodule

// File: doc/pipe_mw_elastic_reg.md
Name: pipe_mw_elastic_reg

Overview:
Parametrised successor to the fixed MEM/WB pipeline register. Carries the write-back bundle (wreg, m2reg, rn, alu, mo) from MEM to WB through a DEPTH-entry elastic buffer with valid/ready handshakes on both sides, synchronous flush and an occupancy count. WB can stall without back-pressuring MEM until the buffer fills, which suits multi-cycle register-file ports and a variable-latency memory path.

Parameters:
DATA_W, 32, width of the alu and mo data fields
RN_W, 5, width of the destination register number
DEPTH, 2, buffer entries; legal range 1..8; DEPTH=1 behaves as a plain stage register with a valid bit
CNT_W, 4, occupancy counter width; must satisfy 2^CNT_W > DEPTH

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of all buffered entries
mvalid  in  1  MEM side presents a bundle
mready  out  1  buffer can accept; equals (count < DEPTH); registered-state only, no path from wready
mwreg  in  1  register-write enable of the MEM bundle
mm2reg  in  1  select memory data for write-back
mrn  in  RN_W  destination register
malu  in  DATA_W  ALU result
mmo  in  DATA_W  memory read data
wvalid  out  1  head entry valid
wready  in  1  WB consumes the head entry
wwreg  out  1  head wreg AND wvalid
wm2reg  out  1  head m2reg AND wvalid
wrn  out  RN_W  head rn; 0 when empty
walu  out  DATA_W  head alu; 0 when empty
wmo  out  DATA_W  head mo; 0 when empty
wdata  out  DATA_W  wm2reg ? wmo : walu (combinational from the outputs)
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset: single clock, synchronous, active-high reset. When reset=1 at a clock edge, count, read pointer and write pointer become 0. As a result wvalid=0, wwreg=0, wm2reg=0, wrn=0, walu=0, wmo=0, wdata=0 and mready=1. Storage contents are don't-care. Reset overrides flush, push and pop.
- Push: mvalid && mready at an edge writes the bundle to slot wp. wp then advances by one, wrapping from DEPTH-1 to 0.
- Pop: wvalid && wready at an edge advances rp by one, with the same wrap rule.
- Count update: push only gives +1, pop only gives -1, push and pop together leave count unchanged.
- Latency: a bundle pushed at edge N appears on the outputs with wvalid=1 after edge N. It is never visible combinationally in the same cycle.
- Order is strict FIFO. No bundle is dropped or duplicated except by flush or reset.
- Full (count==DEPTH): mready=0. A bundle offered with mvalid=1 is not taken, and MEM must hold it. A pop in this cycle raises mready in the next cycle. Push and pop cannot both fire while full.
- Empty (count==0): wvalid=0 and all data outputs read 0, so an empty buffer is a bubble with no register write. wready is ignored.
- Simultaneous push and pop at count=1: the head advances to the new entry and count stays 1, so wvalid stays 1 with no bubble.
- Flush: at the edge, count, rp and wp become 0. A push or pop in the same cycle is discarded. flush has lower priority than reset and higher priority than push/pop.
- Reset or flush mid-stall: the pending head is discarded with no write-back. Normal operation resumes from the next edge.
- wvalid is derived as (count != 0). Output fields are taken from slot rp and gated by wvalid.

Optional Feature:
Macro MW_BYPASS_EN.
- Defined: when count==0 and flush=0, mvalid/mwreg/mm2reg/mrn/malu/mmo are routed combinationally to the w-side outputs. If wready=1 in that cycle, the bundle is consumed with zero latency and not stored. If wready=0, it is pushed normally.
- In bypass mode, wvalid=mvalid while empty, and mready is still (count<DEPTH).
- Not defined: a strict 1-cycle minimum latency as described above, with no combinational m-to-w path.

Test Plan:
- Reset: assert reset for 2 cycles with mvalid=1 and malu=0x1234 -> count=0, wvalid=0, all w-outputs 0, mready=1; the bundle is not captured.
- Streaming: DEPTH=2, wready=1, push rn=3 alu=0xA, then rn=4 alu=0xB, on consecutive cycles -> wrn=3/walu=0xA one cycle after the first push, then 4/0xB; count stays 1; no bubble.
- Fill and stall: wready=0, push 3 bundles -> first two accepted, count=2, mready=0, third held. Raise wready for 1 cycle -> head pops, the third is accepted next cycle, and order is preserved.
- Data select: push m2reg=1 mo=0xDEAD alu=0xBEEF -> wdata=0xDEAD. Push m2reg=0 -> wdata=0xBEEF.
- Flush: count=2 with flush=1 and mvalid=1 on the same edge -> count=0, wvalid=0, wwreg=0; the same-cycle push is discarded.
- Wrap: DEPTH=3, push/pop 10 bundles with random wready -> output sequence exactly equals input sequence across pointer wrap; count never exceeds 3.
